// File: rtl/ysyx_23060203_lsu_if.sv
// AXI4-Lite bus bundle between the LSU (master) and the memory/interconnect (slave).
//   AR: araddr/arvalid/arready   R: rdata/rresp/rvalid/rready
//   AW: awaddr/awvalid/awready   W: wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready
interface ysyx_23060203_lsu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_23060203_lsu.sv
// ysyx_23060203_lsu: load/store unit behind the EXU ALU. Accepts one memory
// instruction at a time, performs a single AXI4-Lite read or write for it, and
// returns the extended load data (or store completion) to the WBU.
//   clk, rstn          clock, synchronous active-low reset
//   in_*               EXU request (valid/ready, addr, wdata, funct3, wen, rd)
//   axi                AXI4-Lite master port
//   out_*              WBU result (valid/ready, data, rd, wen, err)
module ysyx_23060203_lsu #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_addr,
    input  logic [31:0]                in_wdata,
    input  logic [2:0]                 in_funct3,
    input  logic                       in_wen,
    input  logic [4:0]                 in_rd,
    ysyx_23060203_lsu_if.master        axi,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [4:0]                 out_rd,
    output logic                       out_wen,
    output logic                       out_err
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned RD_W   = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        RESP  = 3'd5
    } state_e;

    state_e              state_q,    state_d;
    logic [1:0]          lane_q,     lane_d;
    logic [2:0]          funct3_q,   funct3_d;
    logic                in_ready_q, in_ready_d;
    logic [XLEN-1:0]     araddr_q,   araddr_d;
    logic                arvalid_q,  arvalid_d;
    logic                rready_q,   rready_d;
    logic [XLEN-1:0]     awaddr_q,   awaddr_d;
    logic                awvalid_q,  awvalid_d;
    logic [XLEN-1:0]     wdata_q,    wdata_d;
    logic [STRB_W-1:0]   wstrb_q,    wstrb_d;
    logic                wvalid_q,   wvalid_d;
    logic                bready_q,   bready_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_data_q, out_data_d;
    logic [RD_W-1:0]     out_rd_q,   out_rd_d;
    logic                out_wen_q,  out_wen_d;
    logic                out_err_q,  out_err_d;

    logic [XLEN-1:0]     st_data;
    logic [STRB_W-1:0]   st_strb_base;
    logic [STRB_W-1:0]   st_strb;
    logic                st_undef;
    logic                misaligned;
    logic                ld_undef;
    logic [XLEN-1:0]     rd_byte_sh;
    logic [XLEN-1:0]     rd_half_sh;
    logic [XLEN-1:0]     ld_data;

    // Store lane replication and byte strobes derived from the incoming request
    always_comb begin
        st_data      = in_wdata;
        st_strb_base = 4'b1111;
        case (in_funct3)
            F3_B: begin
                st_data      = {4{in_wdata[7:0]}};
                st_strb_base = 4'b0001;
            end
            F3_H: begin
                st_data      = {2{in_wdata[15:0]}};
                st_strb_base = 4'b0011;
            end
            default: ;
        endcase
        st_strb  = st_strb_base << in_addr[1:0];
        st_undef = in_wen && (in_funct3 > F3_W);
        misaligned = CHECK_ALIGN &&
                     (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
    end

    // Load lane select and sign/zero extension from the returned word
    always_comb begin
        rd_byte_sh = axi.rdata >> {lane_q, 3'b000};
        rd_half_sh = axi.rdata >> {lane_q[1], 4'b0000};
        ld_undef   = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
        case (funct3_q)
            F3_B:    ld_data = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            F3_H:    ld_data = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
            F3_W:    ld_data = axi.rdata;
            F3_BU:   ld_data = {24'h0, rd_byte_sh[7:0]};
            F3_HU:   ld_data = {16'h0, rd_half_sh[15:0]};
            default: ld_data = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        in_ready_d  = in_ready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    lane_d     = in_addr[1:0];
                    funct3_d   = in_funct3;
                    out_rd_d   = in_rd;
                    out_data_d = '0;
                    out_wen_d  = 1'b0;
                    out_err_d  = 1'b0;
                    // Faults (misaligned, or a store width that does not exist) never touch the bus
                    if (misaligned || st_undef) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                    end else if (in_wen) begin
                        state_d   = WR_AW;
                        awaddr_d  = {in_addr[31:2], 2'b00};
                        awvalid_d = 1'b1;
                        wdata_d   = st_data;
                        wstrb_d   = st_strb;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_A;
                        araddr_d  = {in_addr[31:2], 2'b00};
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_A: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (axi.rvalid) begin
                    rready_d    = 1'b0;
                    state_d     = RESP;
                    out_valid_d = 1'b1;
                    if ((axi.rresp != 2'b00) || ld_undef) begin
                        out_err_d = 1'b1;
                    end else begin
                        out_wen_d  = 1'b1;
                        out_data_d = ld_data;
                    end
                end
            end
            WR_AW: begin
                // AW and W complete independently; move on once both are done
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (axi.bvalid) begin
                    bready_d    = 1'b0;
                    state_d     = RESP;
                    out_valid_d = 1'b1;
                    out_err_d   = (axi.bresp != 2'b00);
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            funct3_q    <= '0;
            in_ready_q  <= 1'b1;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            in_ready_q  <= in_ready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_rd      = out_rd_q;
    assign out_wen     = out_wen_q;
    assign out_err     = out_err_q;
endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Bench for ysyx_23060203_lsu: cycle-stepped AXI4-Lite slave with per-channel
// delays, and a reference model of load extension, store lanes and alignment.
module tb_ysyx_23060203_lsu;
    localparam bit CHECK_ALIGN = 1'b1;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_wen;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    int n_cmp;
    int n_fail;

    ysyx_23060203_lsu_if bus ();

    ysyx_23060203_lsu #(.CHECK_ALIGN(CHECK_ALIGN)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_funct3 (in_funct3),
        .in_wen    (in_wen),
        .in_rd     (in_rd),
        .axi       (bus.master),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] araddr, awaddr, wdata, data;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
        logic        wen, err, in_ready0, post_valid, post_ready, post_busy, timeout;
        int          ar_hs, aw_hs, w_hs, r_hs, b_hs, lat, proto;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int unsigned model_size(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (32'd8 * (a % 32'd4))) % 32'd256;
        h = (w >> (32'd16 * ((a % 32'd4) / 32'd2))) % 32'd65536;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd % 32'd256) * 32'h0101_0101;
            3'd1:    return (wd % 32'd65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = model_size(f3);
        return 4'((((32'd1 << sz) - 32'd1) << (a % 32'd4)) % 32'd16);
    endfunction

    // ---------------- driver + slave ----------------
    // Called at a negedge; returns at a negedge after the result handshake.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                           input logic wen, input logic [4:0] rd, input logic [31:0] rdat,
                           input logic [1:0] rr, input logic [1:0] br,
                           input int ar_d, input int aw_d, input int w_d, input int r_d,
                           input int b_d, input int o_d, output obs_t o);
        int ar_n, aw_n, w_n, r_n, b_n, o_n;
        bit ar_go, aw_go, w_go, ar_prev, aw_prev, w_prev, r_go, b_go, done;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        o = '{default: 0};
        ar_n = 0; aw_n = 0; w_n = 0; r_n = 0; b_n = 0; o_n = 0;
        ar_go = 0; aw_go = 0; w_go = 0; ar_prev = 0; aw_prev = 0; w_prev = 0; done = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        o.in_ready0 = in_ready;
        in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_funct3 = f3; in_wen = wen; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom(); in_wdata = $urandom(); in_rd = 5'($urandom());
        for (int c = 1; c <= 80 && !done; c++) begin
            if (c > 1) @(negedge clk);
            // AR
            if (ar_prev && !ar_go && (!bus.arvalid || bus.araddr !== p_araddr)) o.proto++;
            ar_prev = bus.arvalid; p_araddr = bus.araddr; ar_go = 0;
            if (bus.arvalid) begin
                o.araddr = bus.araddr; ar_go = (ar_n >= ar_d); ar_n++;
                if (ar_go) o.ar_hs++;
            end
            bus.arready = ar_go;
            // AW
            if (aw_prev && !aw_go && (!bus.awvalid || bus.awaddr !== p_awaddr)) o.proto++;
            aw_prev = bus.awvalid; p_awaddr = bus.awaddr; aw_go = 0;
            if (bus.awvalid) begin
                o.awaddr = bus.awaddr; aw_go = (aw_n >= aw_d); aw_n++;
                if (aw_go) o.aw_hs++;
            end
            bus.awready = aw_go;
            // W
            if (w_prev && !w_go && (!bus.wvalid || bus.wdata !== p_wdata || bus.wstrb !== p_wstrb))
                o.proto++;
            w_prev = bus.wvalid; p_wdata = bus.wdata; p_wstrb = bus.wstrb; w_go = 0;
            if (bus.wvalid) begin
                o.wdata = bus.wdata; o.wstrb = bus.wstrb; w_go = (w_n >= w_d); w_n++;
                if (w_go) o.w_hs++;
            end
            bus.wready = w_go;
            // R
            r_go = 0;
            if (bus.rready) begin
                r_go = (r_n >= r_d); r_n++;
                if (r_go) o.r_hs++;
            end
            bus.rvalid = r_go;
            bus.rdata  = r_go ? rdat : $urandom();
            bus.rresp  = r_go ? rr : 2'($urandom());
            // B
            b_go = 0;
            if (bus.bready) begin
                b_go = (b_n >= b_d); b_n++;
                if (b_go) o.b_hs++;
            end
            bus.bvalid = b_go;
            bus.bresp  = b_go ? br : 2'($urandom());
            // result
            out_ready = 1'b0;
            if (out_valid) begin
                if (o_n == 0) begin
                    o.lat = c; o.data = out_data; o.rd = out_rd; o.wen = out_wen; o.err = out_err;
                end else if (out_data !== o.data || out_rd !== o.rd || out_wen !== o.wen ||
                             out_err !== o.err) begin
                    o.proto++;
                end
                done = (o_n >= o_d); o_n++;
                out_ready = done;
            end
        end
        o.timeout = !done;
        @(negedge clk);
        out_ready = 1'b0; bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.rvalid = 1'b0; bus.bvalid = 1'b0;
        o.post_valid = out_valid;
        o.post_ready = in_ready;
        o.post_busy  = bus.arvalid | bus.awvalid | bus.wvalid | bus.rready | bus.bready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'd2; in_addr = 32'h8000_0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}
            !== 7'b100_0000) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b want 1000000",
                     {in_ready, out_valid, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready});
        end
        n_cmp++;
        if ({out_data, out_rd, out_wen, out_err} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_out_regs: got data=%h rd=%0d wen=%b err=%b want all 0",
                     out_data, out_rd, out_wen, out_err);
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_load_ext();
        obs_t o;
        run_txn(32'h8000_0003, 32'h0, 3'd0, 1'b0, 5'd10, 32'h80FF_1234, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.araddr !== 32'h8000_0000) begin
            n_fail++; $display("FAIL lb_araddr: got %h want 80000000", o.araddr);
        end
        n_cmp++;
        if ({o.data, o.wen, o.err, o.rd} !== {32'hFFFF_FF80, 1'b1, 1'b0, 5'd10}) begin
            n_fail++;
            $display("FAIL lb_result: got data=%h wen=%b err=%b rd=%0d want ffffff80 1 0 10",
                     o.data, o.wen, o.err, o.rd);
        end
        n_cmp++;
        if (o.lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", o.lat); end
        run_txn(32'h8000_0002, 32'h0, 3'd5, 1'b0, 5'd3, 32'h9ABC_1234, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.data !== 32'h0000_9ABC) begin
            n_fail++; $display("FAIL lhu_data: got %h want 00009abc", o.data);
        end
        run_txn(32'h8000_0002, 32'h0, 3'd1, 1'b0, 5'd4, 32'h9ABC_1234, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.data !== 32'hFFFF_9ABC) begin
            n_fail++; $display("FAIL lh_data: got %h want ffff9abc", o.data);
        end
    endtask

    task automatic test_store_split();
        obs_t o;
        // awready arrives two cycles after wready
        run_txn(32'h8000_0041, 32'h0000_00A5, 3'd0, 1'b1, 5'd0, 32'h0, 2'b00, 2'b00,
                0, 2, 0, 0, 0, 0, o);
        n_cmp++;
        if ({o.wstrb, o.wdata, o.awaddr} !== {4'b0010, 32'hA5A5_A5A5, 32'h8000_0040}) begin
            n_fail++;
            $display("FAIL sb_bus: got strb=%b wdata=%h awaddr=%h want 0010 a5a5a5a5 80000040",
                     o.wstrb, o.wdata, o.awaddr);
        end
        n_cmp++;
        if (o.aw_hs * 100 + o.w_hs * 10 + o.b_hs !== 111) begin
            n_fail++;
            $display("FAIL sb_handshakes: got aw=%0d w=%0d b=%0d want 1 1 1", o.aw_hs, o.w_hs, o.b_hs);
        end
        n_cmp++;
        if ({o.err, o.wen, o.data} !== 34'd0 || o.proto !== 0 || o.lat !== 5) begin
            n_fail++;
            $display("FAIL sb_result: got err=%b wen=%b data=%h proto=%0d lat=%0d want 0 0 0 0 5",
                     o.err, o.wen, o.data, o.proto, o.lat);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(32'h8000_0102, 32'h0, 3'd2, 1'b0, 5'd9, 32'h1234_5678, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.ar_hs !== 0 || o.lat !== 1) begin
            n_fail++; $display("FAIL lw_misaligned_path: got ar_hs=%0d lat=%0d want 0 1", o.ar_hs, o.lat);
        end
        n_cmp++;
        if ({o.err, o.wen, o.data} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL lw_misaligned_out: got err=%b wen=%b data=%h want 1 0 0", o.err, o.wen, o.data);
        end
    endtask

    task automatic test_rresp_hold();
        obs_t o;
        run_txn(32'h8000_0010, 32'h0, 3'd2, 1'b0, 5'd21, 32'hDEAD_BEEF, 2'b10, 2'b00,
                0, 0, 0, 0, 0, 4, o);
        n_cmp++;
        if ({o.err, o.wen} !== 2'b10 || o.rd !== 5'd21) begin
            n_fail++; $display("FAIL rresp_out: got err=%b wen=%b rd=%0d want 1 0 21", o.err, o.wen, o.rd);
        end
        n_cmp++;
        if (o.proto !== 0 || o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rresp_hold: got unstable=%0d valid_after=%b ready_after=%b want 0 0 1",
                     o.proto, o.post_valid, o.post_ready);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        run_txn(32'h8000_0200, 32'h1122_3344, 3'd2, 1'b1, 5'd0, 32'h0, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o1);
        run_txn(32'h8000_0200, 32'h0, 3'd2, 1'b0, 5'd5, 32'h1122_3344, 2'b00, 2'b00,
                0, 0, 0, 0, 0, 0, o2);
        n_cmp++;
        if (o1.lat !== 3 || o2.lat !== 3 || o2.in_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timing: got lat1=%0d lat2=%0d ready=%b want 3 3 1", o1.lat, o2.lat, o2.in_ready0);
        end
        n_cmp++;
        if (o2.data !== 32'h1122_3344 || o1.wstrb !== 4'hF) begin
            n_fail++; $display("FAIL b2b_data: got data=%h strb=%b want 11223344 1111", o2.data, o1.wstrb);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_addr = 32'h8000_0010; in_funct3 = 3'd2; in_wen = 1'b0; in_rd = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_arvalid: got %b want 1", bus.arvalid); end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        n_cmp++;
        if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rready: got %b want 1", bus.rready); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_cmp++;
        if ({in_ready, bus.rready, out_valid, bus.arvalid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_after: got in_ready=%b rready=%b out_valid=%b arvalid=%b want 1 0 0 0",
                     in_ready, bus.rready, out_valid, bus.arvalid);
        end
        bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA; bus.rresp = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.rready, out_valid, in_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL rstmid_abandon: got rready=%b out_valid=%b in_ready=%b want 0 0 1",
                         bus.rready, out_valid, in_ready);
            end
        end
        bus.rvalid = 1'b0;
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a, wd, rdat, e_data;
        logic [2:0]  f3;
        logic [1:0]  rr, br;
        logic [4:0]  rd;
        logic        wen, flt, undef, e_err, e_wen;
        int ar_d, aw_d, w_d, r_d, b_d, o_d, e_lat, e_hs, hs;
        for (int i = 0; i < 60; i++) begin
            wen = 1'($urandom_range(0, 1));
            if (wen) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                    4: f3 = 3'd5; 5: f3 = 3'd3; default: f3 = 3'd7;
                endcase
            end
            a = {8'h80, 24'($urandom())}; wd = $urandom(); rdat = $urandom(); rd = 5'($urandom());
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ar_d = $urandom_range(0, 2); aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3);
            r_d = $urandom_range(0, 2); b_d = $urandom_range(0, 2); o_d = $urandom_range(0, 2);
            run_txn(a, wd, f3, wen, rd, rdat, rr, br, ar_d, aw_d, w_d, r_d, b_d, o_d, o);

            flt   = CHECK_ALIGN && ((a % model_size(f3)) != 0);
            undef = !wen && (f3 == 3'd3 || f3 == 3'd7);
            if (flt) begin
                e_err = 1'b1; e_wen = 1'b0; e_data = 32'h0; e_lat = 1; e_hs = 0;
            end else if (wen) begin
                e_err = (br != 2'b00); e_wen = 1'b0; e_data = 32'h0;
                e_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d; e_hs = 1101;
            end else begin
                e_err = (rr != 2'b00) || undef; e_wen = !e_err;
                e_data = e_err ? o.data : model_load(f3, a, rdat);
                e_lat = 3 + ar_d + r_d; e_hs = 10010;
            end
            if (undef) begin
                e_lat = o.lat; e_hs = o.ar_hs * 10000 + o.aw_hs * 1000 + o.w_hs * 100 + o.r_hs * 10 + o.b_hs;
            end
            hs = o.ar_hs * 10000 + o.aw_hs * 1000 + o.w_hs * 100 + o.r_hs * 10 + o.b_hs;

            n_cmp++;
            if ({o.err, o.wen, o.rd} !== {e_err, e_wen, rd} || o.data !== e_data) begin
                n_fail++;
                $display("FAIL rnd%0d_result: f3=%0d wen=%b addr=%h got err=%b wen=%b rd=%0d data=%h want %b %b %0d %h",
                         i, f3, wen, a, o.err, o.wen, o.rd, o.data, e_err, e_wen, rd, e_data);
            end
            n_cmp++;
            if (o.lat !== e_lat || hs !== e_hs || o.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: got lat=%0d hs=%0d timeout=%b want lat=%0d hs=%0d timeout=0",
                         i, o.lat, hs, o.timeout, e_lat, e_hs);
            end
            n_cmp++;
            if (o.proto !== 0 || o.in_ready0 !== 1'b1 || o.post_valid !== 1'b0 ||
                o.post_ready !== 1'b1 || o.post_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_protocol: got unstable=%0d ready_before=%b valid_after=%b ready_after=%b busy_after=%b want 0 1 0 1 0",
                         i, o.proto, o.in_ready0, o.post_valid, o.post_ready, o.post_busy);
            end
            if (!flt && !wen) begin
                n_cmp++;
                if (o.araddr !== {a[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL rnd%0d_araddr: got %h want %h", i, o.araddr, {a[31:2], 2'b00});
                end
            end
            if (!flt && wen) begin
                n_cmp++;
                if (o.awaddr !== {a[31:2], 2'b00} || o.wdata !== model_wdata(f3, wd) ||
                    o.wstrb !== model_wstrb(f3, a)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_store_bus: got awaddr=%h wdata=%h strb=%b want %h %h %b", i,
                             o.awaddr, o.wdata, o.wstrb, {a[31:2], 2'b00}, model_wdata(f3, wd),
                             model_wstrb(f3, a));
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rstn = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
        in_wen = 1'b0; in_rd = '0; out_ready = 1'b0;
        bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = '0; bus.bvalid = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_ext();
        test_store_split();
        test_misaligned();
        test_rresp_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
